// File: rtl/svc_axi_pkg.sv
// Shared AXI codes and FSM state types for the svc_axi_mem block.
// Burst/response encodings follow AXI4; burst_illegal flags bursts the memory cannot serve.
package svc_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_e;

    // Only full-width INCR bursts are served; anything else is answered with SLVERR.
    function automatic logic burst_illegal(input logic [1:0] burst,
                                           input logic [2:0] size,
                                           input logic [2:0] full_size);
        return (burst != BURST_INCR) || (size != full_size);
    endfunction

endpackage

// File: rtl/svc_axi_burst_addr.sv
// Next-word address calculation for one AXI burst beat.
// Word addresses wrap modulo the memory depth through natural truncation.
module svc_axi_burst_addr
    import svc_axi_pkg::*;
#(
    parameter int WORD_ADDR_WIDTH = 9
) (
    input  logic [WORD_ADDR_WIDTH-1:0] cur_addr,
    input  logic [1:0]                 burst,
    input  logic [7:0]                 len,
    output logic [WORD_ADDR_WIDTH-1:0] next_addr
);

    logic [WORD_ADDR_WIDTH-1:0] incr_addr;
    logic [WORD_ADDR_WIDTH-1:0] wrap_mask;

    // WRAP keeps the upper bits and lets the low len-sized field roll over.
    always_comb begin
        incr_addr = cur_addr + WORD_ADDR_WIDTH'(1);
        wrap_mask = WORD_ADDR_WIDTH'(len);
        next_addr = incr_addr;
        case (burst)
            BURST_FIXED: next_addr = cur_addr;
            BURST_WRAP:  next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:     next_addr = incr_addr;
        endcase
    end

endmodule

// File: rtl/svc_axi_mem.sv
// AXI4 subordinate memory with independent write and read burst FSMs.
// Optional SLVERR checking of burst/size/wlast is enabled by defining SVC_AXI_MEM_SLVERR_EN.
module svc_axi_mem
    import svc_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 10,
    parameter int AXI_DATA_WIDTH = 16,
    parameter int AXI_ID_WIDTH   = 4,
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,

    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [AXI_STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                      s_axi_wlast,

    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]                s_axi_bresp,

    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,

    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast
);

    localparam int ADDR_LSB      = $clog2(AXI_STRB_WIDTH);
    localparam int WORD_AW       = AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int DEPTH         = 2 ** WORD_AW;
    localparam logic [2:0] FULL_SIZE = 3'(ADDR_LSB);

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    w_state_e                  wstate;
    logic [WORD_AW-1:0]        waddr;
    logic [WORD_AW-1:0]        w_next;
    logic [AXI_ID_WIDTH-1:0]   wid_q;
    logic [7:0]                wlen;
    logic [8:0]                wcnt;
    logic [1:0]                wburst;
    logic                      werr;

    r_state_e                  rstate;
    logic [WORD_AW-1:0]        raddr;
    logic [WORD_AW-1:0]        r_next;
    logic [7:0]                rlen;
    logic [8:0]                rcnt;
    logic [1:0]                rburst;
    logic                      rerr;

    logic [WORD_AW-1:0]        aw_word;
    logic [WORD_AW-1:0]        ar_word;
    logic                      w_final;
    logic                      aw_err;
    logic                      ar_err;
    logic                      w_beat_err;
    logic [1:0]                aw_burst_eff;
    logic [1:0]                ar_burst_eff;
    logic                      mem_we;
    logic                      unused_ok;

    assign aw_word = s_axi_awaddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_word = s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign w_final = (wcnt == {1'b0, wlen});

`ifdef SVC_AXI_MEM_SLVERR_EN
    assign aw_err       = burst_illegal(s_axi_awburst, s_axi_awsize, FULL_SIZE);
    assign ar_err       = burst_illegal(s_axi_arburst, s_axi_arsize, FULL_SIZE);
    assign w_beat_err   = (s_axi_wlast != w_final);
    assign aw_burst_eff = s_axi_awburst;
    assign ar_burst_eff = s_axi_arburst;
    assign unused_ok    = ^{s_axi_awaddr, s_axi_araddr};
`else
    assign aw_err       = 1'b0;
    assign ar_err       = 1'b0;
    assign w_beat_err   = 1'b0;
    assign aw_burst_eff = BURST_INCR;
    assign ar_burst_eff = BURST_INCR;
    assign unused_ok    = ^{s_axi_awaddr, s_axi_araddr, s_axi_awsize, s_axi_awburst,
                            s_axi_arsize, s_axi_arburst, s_axi_wlast, FULL_SIZE};
`endif

    assign s_axi_awready = (wstate == W_IDLE);
    assign s_axi_wready  = (wstate == W_DATA);
    assign s_axi_arready = (rstate == R_IDLE);
    assign mem_we        = (wstate == W_DATA) && s_axi_wvalid && !werr && !w_beat_err;

    svc_axi_burst_addr #(.WORD_ADDR_WIDTH(WORD_AW)) u_waddr (
        .cur_addr  (waddr),
        .burst     (wburst),
        .len       (wlen),
        .next_addr (w_next)
    );

    svc_axi_burst_addr #(.WORD_ADDR_WIDTH(WORD_AW)) u_raddr (
        .cur_addr  (raddr),
        .burst     (rburst),
        .len       (rlen),
        .next_addr (r_next)
    );

    // The array is deliberately not reset so a reset leaves contents intact.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[waddr][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate       <= W_IDLE;
            waddr        <= '0;
            wid_q        <= '0;
            wlen         <= '0;
            wcnt         <= '0;
            wburst       <= BURST_INCR;
            werr         <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bid    <= '0;
            s_axi_bresp  <= RESP_OKAY;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (s_axi_awvalid) begin
                        waddr  <= aw_word;
                        wid_q  <= s_axi_awid;
                        wlen   <= s_axi_awlen;
                        wcnt   <= '0;
                        wburst <= aw_burst_eff;
                        werr   <= aw_err;
                        wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wvalid) begin
                        waddr <= w_next;
                        wcnt  <= wcnt + 9'd1;
                        if (w_beat_err) begin
                            werr <= 1'b1;
                        end
                        if (w_final) begin
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= wid_q;
                            s_axi_bresp  <= (werr || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                            wstate       <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        wstate       <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Each accepted R beat prefetches the next word so rready=1 streams one beat per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate       <= R_IDLE;
            raddr        <= '0;
            rlen         <= '0;
            rcnt         <= '0;
            rburst       <= BURST_INCR;
            rerr         <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rid    <= '0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
            s_axi_rlast  <= 1'b0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (s_axi_arvalid) begin
                        raddr        <= ar_word;
                        rlen         <= s_axi_arlen;
                        rcnt         <= '0;
                        rburst       <= ar_burst_eff;
                        rerr         <= ar_err;
                        s_axi_rvalid <= 1'b1;
                        s_axi_rid    <= s_axi_arid;
                        s_axi_rdata  <= ar_err ? '0 : mem[ar_word];
                        s_axi_rresp  <= ar_err ? RESP_SLVERR : RESP_OKAY;
                        s_axi_rlast  <= (s_axi_arlen == 8'd0);
                        rstate       <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (s_axi_rlast) begin
                            s_axi_rvalid <= 1'b0;
                            s_axi_rlast  <= 1'b0;
                            rstate       <= R_IDLE;
                        end else begin
                            raddr       <= r_next;
                            rcnt        <= rcnt + 9'd1;
                            s_axi_rlast <= ((rcnt + 9'd1) == {1'b0, rlen});
                            s_axi_rdata <= rerr ? '0 : mem[r_next];
                        end
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_svc_axi_mem.sv
// Randomized self-checking bench for svc_axi_mem against an array-based memory model.
// Covers SLVERR cases when SVC_AXI_MEM_SLVERR_EN is defined.
module tb_svc_axi_mem;
    import svc_axi_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 16;
    localparam int IW    = 4;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 512;

    logic          clk;
    logic          rst_n;
    logic          s_axi_awvalid, s_axi_awready;
    logic [AW-1:0] s_axi_awaddr;
    logic [IW-1:0] s_axi_awid;
    logic [7:0]    s_axi_awlen;
    logic [2:0]    s_axi_awsize;
    logic [1:0]    s_axi_awburst;
    logic          s_axi_wvalid, s_axi_wready;
    logic [DW-1:0] s_axi_wdata;
    logic [SW-1:0] s_axi_wstrb;
    logic          s_axi_wlast;
    logic          s_axi_bvalid, s_axi_bready;
    logic [IW-1:0] s_axi_bid;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_arvalid, s_axi_arready;
    logic [AW-1:0] s_axi_araddr;
    logic [IW-1:0] s_axi_arid;
    logic [7:0]    s_axi_arlen;
    logic [2:0]    s_axi_arsize;
    logic [1:0]    s_axi_arburst;
    logic          s_axi_rvalid, s_axi_rready;
    logic [IW-1:0] s_axi_rid;
    logic [DW-1:0] s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rlast;

    logic [DW-1:0] model_mem [DEPTH];
    logic [DW-1:0] wdata_q [$];
    logic [SW-1:0] wstrb_q [$];
    int            checks = 0;
    int            errors = 0;

    svc_axi_mem #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awid(s_axi_awid), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
        .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
        .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bid(s_axi_bid),
        .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
        .s_axi_arid(s_axi_arid), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rid(s_axi_rid),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit burst_is_err(input logic [1:0] burst);
        bit err;
        err = 1'b0;
`ifdef SVC_AXI_MEM_SLVERR_EN
        err = (burst != BURST_INCR);
`endif
        return err;
    endfunction

    task automatic fill_queues(input int len, input bit full_strb);
        wdata_q.delete();
        wstrb_q.delete();
        for (int i = 0; i <= len; i++) begin
            wdata_q.push_back(DW'($urandom));
            wstrb_q.push_back(full_strb ? SW'(3) : SW'($urandom_range(0, 3)));
        end
    endtask

    task automatic write_burst(input int word, input int len, input int id,
                               input logic [1:0] burst, input int bdelay);
        bit err;
        int tmo;
        int w;
        err = burst_is_err(burst);
        s_axi_awvalid = 1'b1;
        s_axi_awaddr  = AW'(word * SW);
        s_axi_awid    = IW'(id);
        s_axi_awlen   = 8'(len);
        s_axi_awsize  = 3'd1;
        s_axi_awburst = burst;
        tmo = 0;
        while (!s_axi_awready && tmo < 100) begin
            wait_cycle();
            tmo++;
        end
        if (!s_axi_awready) begin
            checkOutput("aw_timeout", 32'(s_axi_awready), 32'd1);
            s_axi_awvalid = 1'b0;
            return;
        end
        wait_cycle();
        s_axi_awvalid = 1'b0;
        checkOutput("wready_after_aw", 32'(s_axi_wready), 32'd1);
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                s_axi_wvalid = 1'b0;
                wait_cycle();
            end
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = wdata_q[i];
            s_axi_wstrb  = wstrb_q[i];
            s_axi_wlast  = (i == len);
            tmo = 0;
            while (!s_axi_wready && tmo < 100) begin
                wait_cycle();
                tmo++;
            end
            if (!s_axi_wready) begin
                checkOutput("w_timeout", 32'(s_axi_wready), 32'd1);
                s_axi_wvalid = 1'b0;
                return;
            end
            wait_cycle();
            if (!err) begin
                w = (word + i) % DEPTH;
                for (int b = 0; b < SW; b++) begin
                    if (wstrb_q[i][b]) model_mem[w][8*b +: 8] = wdata_q[i][8*b +: 8];
                end
            end
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        checkOutput("bvalid", 32'(s_axi_bvalid), 32'd1);
        checkOutput("bid", 32'(s_axi_bid), 32'(id));
        checkOutput("bresp", 32'(s_axi_bresp), err ? 32'd2 : 32'd0);
        for (int d = 0; d < bdelay; d++) begin
            wait_cycle();
            checkOutput("bvalid_hold", 32'(s_axi_bvalid), 32'd1);
            checkOutput("bid_hold", 32'(s_axi_bid), 32'(id));
        end
        s_axi_bready = 1'b1;
        wait_cycle();
        s_axi_bready = 1'b0;
        checkOutput("bvalid_clear", 32'(s_axi_bvalid), 32'd0);
        checkOutput("awready_after_b", 32'(s_axi_awready), 32'd1);
    endtask

    // mode 0: rready always 1, mode 1: random, mode 2: repeating 1,0,0,1
    task automatic read_burst(input int word, input int len, input int id,
                              input logic [1:0] burst, input int mode);
        bit err;
        bit rr;
        int tmo;
        int i;
        int cyc;
        logic [DW-1:0] exp_data;
        err = burst_is_err(burst);
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = AW'(word * SW);
        s_axi_arid    = IW'(id);
        s_axi_arlen   = 8'(len);
        s_axi_arsize  = 3'd1;
        s_axi_arburst = burst;
        tmo = 0;
        while (!s_axi_arready && tmo < 100) begin
            wait_cycle();
            tmo++;
        end
        if (!s_axi_arready) begin
            checkOutput("ar_timeout", 32'(s_axi_arready), 32'd1);
            s_axi_arvalid = 1'b0;
            return;
        end
        wait_cycle();
        s_axi_arvalid = 1'b0;
        i = 0;
        cyc = 0;
        while (i <= len && cyc < 8 * (len + 1) + 50) begin
            checkOutput("rvalid", 32'(s_axi_rvalid), 32'd1);
            if (!s_axi_rvalid) break;
            exp_data = err ? '0 : model_mem[(word + i) % DEPTH];
            checkOutput("rdata", 32'(s_axi_rdata), 32'(exp_data));
            checkOutput("rlast", 32'(s_axi_rlast), 32'(i == len));
            checkOutput("rid", 32'(s_axi_rid), 32'(id));
            checkOutput("rresp", 32'(s_axi_rresp), err ? 32'd2 : 32'd0);
            case (mode)
                1:       rr = 1'($urandom_range(0, 1));
                2:       rr = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rr = 1'b1;
            endcase
            s_axi_rready = rr;
            wait_cycle();
            cyc++;
            if (rr) i++;
        end
        s_axi_rready = 1'b0;
        if (i <= len) checkOutput("read_incomplete", 32'(i), 32'(len + 1));
        checkOutput("rvalid_end", 32'(s_axi_rvalid), 32'd0);
        checkOutput("arready_end", 32'(s_axi_arready), 32'd1);
    endtask

    task automatic applyStimulus(input int count);
        int word;
        int len;
        for (int n = 0; n < count; n++) begin
            word = $urandom_range(0, DEPTH - 1);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 7);
            fill_queues(len, 1'b0);
            write_burst(word, len, $urandom_range(0, 15), BURST_INCR, $urandom_range(0, 3));
            read_burst(word, len, $urandom_range(0, 15), BURST_INCR, $urandom_range(0, 2));
            read_burst($urandom_range(0, DEPTH - 1), $urandom_range(0, 15),
                       $urandom_range(0, 15), BURST_INCR, $urandom_range(0, 2));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_awready"}, 32'(s_axi_awready), 32'd1);
        checkOutput({tag, "_arready"}, 32'(s_axi_arready), 32'd1);
        checkOutput({tag, "_wready"}, 32'(s_axi_wready), 32'd0);
        checkOutput({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd0);
        checkOutput({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd0);
        checkOutput({tag, "_rlast"}, 32'(s_axi_rlast), 32'd0);
        checkOutput({tag, "_bresp"}, 32'(s_axi_bresp), 32'd0);
        checkOutput({tag, "_rresp"}, 32'(s_axi_rresp), 32'd0);
        checkOutput({tag, "_bid"}, 32'(s_axi_bid), 32'd0);
        checkOutput({tag, "_rid"}, 32'(s_axi_rid), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] old_word;
        logic [DW-1:0] new_word;

        rst_n         = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0;
        s_axi_awsize  = 3'd1; s_axi_awburst = BURST_INCR;
        s_axi_wvalid  = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
        s_axi_arsize  = 3'd1; s_axi_arburst = BURST_INCR;
        s_axi_rready  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_cycle();

        // Fill the whole memory with two 256-beat bursts (len=255).
        for (int h = 0; h < 2; h++) begin
            fill_queues(255, 1'b1);
            write_burst(h * 256, 255, 1, BURST_INCR, 0);
        end
        read_burst(0, 255, 2, BURST_INCR, 0);

        // Single write at 0x10.
        wdata_q = '{16'hBEEF};
        wstrb_q = '{2'b11};
        write_burst(16'h10 / SW, 0, 3, BURST_INCR, 2);
        read_burst(16'h10 / SW, 0, 5, BURST_INCR, 0);

        // Burst of 0..7 at 0x20, streamed and then back-pressured.
        wdata_q.delete();
        wstrb_q.delete();
        for (int i = 0; i < 8; i++) begin
            wdata_q.push_back(DW'(i));
            wstrb_q.push_back(2'b11);
        end
        write_burst(16'h20 / SW, 7, 7, BURST_INCR, 0);
        read_burst(16'h20 / SW, 7, 8, BURST_INCR, 0);
        read_burst(16'h20 / SW, 3, 9, BURST_INCR, 2);

        // Wrap from the top word back to word 0.
        fill_queues(3, 1'b1);
        write_burst(16'h3FE / SW, 3, 10, BURST_INCR, 1);
        read_burst(DEPTH - 1, 3, 11, BURST_INCR, 1);
        read_burst(0, 2, 12, BURST_INCR, 0);

        // Partial strobe over 0x1234.
        wdata_q = '{16'h1234};
        wstrb_q = '{2'b11};
        write_burst(40, 0, 1, BURST_INCR, 0);
        wdata_q = '{16'hABCD};
        wstrb_q = '{2'b01};
        write_burst(40, 0, 1, BURST_INCR, 0);
        read_burst(40, 0, 2, BURST_INCR, 0);

        // Read and write of the same word on the same edge returns the old data.
        old_word = model_mem[100];
        new_word = ~old_word;
        s_axi_awvalid = 1'b1; s_axi_awaddr = AW'(100 * SW); s_axi_awid = 4'd2;
        s_axi_awlen = 8'd0; s_axi_awburst = BURST_INCR;
        wait_cycle();
        s_axi_awvalid = 1'b0;
        checkOutput("rf_wready", 32'(s_axi_wready), 32'd1);
        checkOutput("rf_arready", 32'(s_axi_arready), 32'd1);
        s_axi_wvalid = 1'b1; s_axi_wdata = new_word; s_axi_wstrb = 2'b11; s_axi_wlast = 1'b1;
        s_axi_arvalid = 1'b1; s_axi_araddr = AW'(100 * SW); s_axi_arid = 4'd6;
        s_axi_arlen = 8'd0; s_axi_arburst = BURST_INCR;
        wait_cycle();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_arvalid = 1'b0;
        checkOutput("rf_rvalid", 32'(s_axi_rvalid), 32'd1);
        checkOutput("rf_rdata_old", 32'(s_axi_rdata), 32'(old_word));
        checkOutput("rf_bvalid", 32'(s_axi_bvalid), 32'd1);
        model_mem[100] = new_word;
        s_axi_rready = 1'b1; s_axi_bready = 1'b1;
        wait_cycle();
        s_axi_rready = 1'b0; s_axi_bready = 1'b0;
        read_burst(100, 0, 3, BURST_INCR, 0);

        applyStimulus(25);

`ifdef SVC_AXI_MEM_SLVERR_EN
        fill_queues(1, 1'b1);
        write_burst(60, 1, 4, BURST_FIXED, 1);
        read_burst(60, 1, 5, BURST_INCR, 0);
        read_burst(60, 1, 6, BURST_FIXED, 1);
`endif

        // Reset in the middle of a read burst.
        s_axi_arvalid = 1'b1; s_axi_araddr = AW'(16 * SW); s_axi_arid = 4'd9;
        s_axi_arlen = 8'd7; s_axi_arburst = BURST_INCR;
        wait_cycle();
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        wait_cycle();
        wait_cycle();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midread");
        s_axi_rready = 1'b0;
        wait_cycle();
        rst_n = 1'b1;
        wait_cycle();
        read_burst(16, 7, 4, BURST_INCR, 1);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/svc_axi_mem.md
SVC_AXI_MEM -- requirements
Module: svc_axi_mem

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 10, byte address width; depth = 2**(AXI_ADDR_WIDTH - log2(AXI_STRB_WIDTH)) words.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 16, data bus width (multiple of 8).
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, transaction ID width.
REQ-004 SHALL have localparam AXI_STRB_WIDTH = AXI_DATA_WIDTH/8.
REQ-005 SHALL have port clk, input, 1, single clock; every port is synchronous to it.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have AXI4 subordinate write ports s_axi_aw{valid,ready,addr,id,len[7:0],size[2:0],burst[1:0]}, s_axi_w{valid,ready,data,strb,last} and s_axi_b{valid,ready,id,resp[1:0]}.
REQ-008 SHALL have AXI4 subordinate read ports s_axi_ar{valid,ready,addr,id,len,size,burst} and s_axi_r{valid,ready,id,data,resp,last}.

Function
REQ-009 Write FSM SHALL have states W_IDLE -> W_DATA -> W_RESP -> W_IDLE; the read FSM SHALL have states R_IDLE -> R_DATA -> R_IDLE; the two FSMs SHALL run independently.
REQ-010 s_axi_awready SHALL equal (wstate==W_IDLE); AW handshake at cycle N SHALL latch addr/id/len and assert s_axi_wready from N+1.
REQ-011 Each W handshake SHALL write the bytes enabled by wstrb at the current word address, then advance the address by AXI_STRB_WIDTH.
REQ-012 The burst SHALL end on beat index awlen; s_axi_bvalid SHALL assert the next cycle with bid = latched awid and hold with stable bid/bresp until bready.
REQ-013 After the B handshake, wstate SHALL be W_IDLE, so awready is 1 on the following cycle.
REQ-014 s_axi_arready SHALL equal (rstate==R_IDLE); AR handshake at N SHALL present beat 0 with rvalid=1 at N+1.
REQ-015 With rready held at 1, the read path SHALL return one beat per cycle (prefetch the next word on each R handshake); rdata/rid/rresp/rlast SHALL stay stable while rvalid && !rready.
REQ-016 rlast SHALL be 1 only on beat arlen; the R handshake of that beat SHALL return to R_IDLE.
REQ-017 Addresses SHALL wrap modulo the memory depth; beats crossing the top word SHALL continue at word 0.
REQ-018 A same-cycle read and write to one word SHALL return the old data (read-first).
REQ-019 Length arithmetic SHALL use a 9-bit beat counter, so awlen/arlen=255 yields 256 beats with no overflow.
REQ-020 OKAY SHALL be 2'b00 and SLVERR SHALL be 2'b10.

Reset
REQ-021 rst_n low SHALL asynchronously force both FSMs to idle, with awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=rresp=0 and bid=rid=0.
REQ-022 A reset mid-burst SHALL abandon the transaction without a B or R response, and SHALL leave memory contents unchanged (the array is not reset).

Configuration
REQ-023 With macro SVC_AXI_MEM_SLVERR_EN defined, the following conditions SHALL yield SLVERR: burst != INCR, size != log2(AXI_STRB_WIDTH), or wlast disagreeing with the beat counter.
REQ-024 With SVC_AXI_MEM_SLVERR_EN defined, erroneous write bursts SHALL consume all beats without modifying memory, and erroneous read bursts SHALL return all beats with rresp=SLVERR and rdata=0.
REQ-025 Without SVC_AXI_MEM_SLVERR_EN, all bursts SHALL be treated as full-width INCR, wlast SHALL be ignored, and every response SHALL be OKAY.

Structure
REQ-026 Response codes (OKAY, SLVERR) and burst codes (FIXED, INCR, WRAP) SHALL live in shared package svc_axi_pkg.
REQ-027 Next-address and wrap calculation SHALL be one sub-module, svc_axi_burst_addr, instantiated once for the write path and once for the read path.

Verification
REQ-028 Single write: AW addr=0x10, len=0, id=3 plus W data=0xBEEF, strb=2'b11 -> bvalid at the cycle after the W handshake with bid=3, bresp=0; a read of 0x10 returns 0xBEEF with rlast=1.
REQ-029 Burst: write len=7 of data 0..7 at 0x20, then read len=7 with rready=1 -> 8 consecutive rvalid cycles, data 0..7, rlast only on beat 7.
REQ-030 Backpressure: rready toggling 1,0,0,1 during a len=3 read -> rdata held stable while stalled, and no beat lost or duplicated.
REQ-031 Wrap: write len=3 at the last word (0x3FE for 10-bit/16-bit) -> data lands at words 511, 0, 1, 2.
REQ-032 Partial strobe: word holds 0x1234, write 0xABCD with strb=2'b01 -> a readback returns 0x12CD.
REQ-033 With SVC_AXI_MEM_SLVERR_EN, a FIXED burst write of len=1 -> bresp=2'b10 and memory unchanged; with reset asserted mid-read, rvalid drops immediately and arready=1.
